// File: rtl/encode42_pkg.sv
// Shared types and constants for the sequential 4-to-2 encoder.
package encode42_pkg;

  localparam int unsigned MASK_W = 4;
  localparam int unsigned IDX_W  = 2;

  typedef enum logic [0:0] {
    IDLE,
    EMIT
  } state_e;

  // True when exactly one bit of the mask is set.
  function automatic logic is_onehot(input logic [MASK_W-1:0] mask);
    return (mask != '0) && ((mask & (mask - MASK_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/prio_pick4.sv
// Combinational priority pick over a 4-bit mask: index of the winning bit and
// a one-hot vector that clears it. An empty mask yields index 0 and no clear.
module prio_pick4
  import encode42_pkg::*;
(
  input  logic [MASK_W-1:0] mask,
  input  logic              prio_lsb,
  output logic [IDX_W-1:0]  idx,
  output logic [MASK_W-1:0] clr
);

  always_comb begin
    idx = '0;
    clr = '0;
    if (prio_lsb) begin
      // Scan downward so the lowest set bit is written last and wins.
      for (int i = MASK_W - 1; i >= 0; i--) begin
        if (mask[i]) begin
          idx = IDX_W'(i);
        end
      end
    end else begin
      for (int i = 0; i < MASK_W; i++) begin
        if (mask[i]) begin
          idx = IDX_W'(i);
        end
      end
    end
    clr[idx] = |mask;
  end

endmodule

// File: rtl/encode42_seq.sv
// Sequential 4-to-2 encoder: serialises the set bits of a request mask into
// indices, one per output handshake. Optional err pulse: ENCODE42_ZERO_ERR_EN.
module encode42_seq
  import encode42_pkg::*;
#(
  parameter bit PRIO_LSB = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [MASK_W-1:0] in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [IDX_W-1:0]  out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
`ifdef ENCODE42_ZERO_ERR_EN
  ,
  output logic              err
`endif
);

  state_e            state;
  logic [MASK_W-1:0] pend;
  logic [MASK_W-1:0] pend_d;
  logic [MASK_W-1:0] clr_q;
  logic [MASK_W-1:0] clr_d;
  logic [IDX_W-1:0]  idx_d;
  logic              in_hs;
  logic              out_hs;

  assign in_ready = (state == IDLE) && !reset;
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;

  always_comb begin
    pend_d = pend;
    if (in_hs) begin
      pend_d = in;
    end else if (out_hs) begin
      pend_d = pend & ~clr_q;
    end
  end

  // Picking on the next-state mask lets out/out_last/clear be registered
  // alongside pend, so the outputs never depend on same-cycle inputs.
  prio_pick4 u_pick (
    .mask     (pend_d),
    .prio_lsb (PRIO_LSB),
    .idx      (idx_d),
    .clr      (clr_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pend      <= '0;
      clr_q     <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      pend      <= pend_d;
      clr_q     <= clr_d;
      out       <= idx_d;
      out_valid <= (pend_d != '0);
      out_last  <= is_onehot(pend_d);
      unique case (state)
        IDLE: begin
          if (in_hs && (in != '0)) begin
            state <= EMIT;
          end
        end
        EMIT: begin
          if (out_hs && out_last) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ENCODE42_ZERO_ERR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else begin
      err <= in_hs && (in == '0);
    end
  end
`endif

endmodule

// File: tb/tb_encode42_seq.sv
// Bench for encode42_seq: one LSB-first and one MSB-first instance, each checked
// every cycle against a list-of-indices model, plus literal directed checks.
module tb_encode42_seq;

  logic       clk;
  logic       reset;
  logic [3:0] in_s        [2];
  logic       in_valid_s  [2];
  logic       in_ready_s  [2];
  logic [1:0] out_s       [2];
  logic       out_valid_s [2];
  logic       out_ready_s [2];
  logic       out_last_s  [2];
  logic       err_s       [2];

  int checks;
  int errors;

  // Model: the ordered list of indices still owed for the accepted mask.
  int lst [2][4];
  int n   [2];
  int pos [2];
  bit err_exp [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    encode42_seq #(
      .PRIO_LSB (g == 0)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in        (in_s[g]),
      .in_valid  (in_valid_s[g]),
      .in_ready  (in_ready_s[g]),
      .out       (out_s[g]),
      .out_valid (out_valid_s[g]),
      .out_ready (out_ready_s[g]),
      .out_last  (out_last_s[g])
`ifdef ENCODE42_ZERO_ERR_EN
      ,
      .err       (err_s[g])
`endif
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        n[i]       = 0;
        pos[i]     = 0;
        err_exp[i] = 1'b0;
      end else begin
        err_exp[i] = 1'b0;
        if (pos[i] < n[i]) begin
          if (out_ready_s[i]) pos[i]++;
        end else if (in_valid_s[i]) begin
          n[i]   = 0;
          pos[i] = 0;
          for (int b = 0; b < 4; b++) begin
            int bi;
            bi = (i == 0) ? b : 3 - b;
            if (in_s[i][bi]) begin
              lst[i][n[i]] = bi;
              n[i]++;
            end
          end
          if (n[i] == 0) err_exp[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      bit busy;
      busy = pos[i] < n[i];
      chk($sformatf("m%0d_out_valid", i), int'(out_valid_s[i]), int'(busy));
      chk($sformatf("m%0d_in_ready", i), int'(in_ready_s[i]), int'(!reset && !busy));
      if (busy) begin
        chk($sformatf("m%0d_out", i), int'(out_s[i]), lst[i][pos[i]]);
        chk($sformatf("m%0d_out_last", i), int'(out_last_s[i]), int'(pos[i] == n[i] - 1));
      end
`ifdef ENCODE42_ZERO_ERR_EN
      chk($sformatf("m%0d_err", i), int'(err_s[i]), int'(err_exp[i]));
`endif
    end
  endtask

  // One clock: model follows the edge, then everything is compared mid-cycle.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_s[i]        = 4'b0;
      in_valid_s[i]  = 1'b0;
      out_ready_s[i] = 1'b0;
      n[i]           = 0;
      pos[i]         = 0;
      err_exp[i]     = 1'b0;
    end
    @(negedge clk);
    step();
    step();
    reset = 1'b0;
    step();
    chk("rst_in_ready", int'(in_ready_s[0]), 1);
    chk("rst_out_valid", int'(out_valid_s[0]), 0);
    chk("rst_out", int'(out_s[0]), 0);
    chk("rst_out_last", int'(out_last_s[0]), 0);

    // Serialize 1011, lowest first.
    in_s[0] = 4'b1011; in_valid_s[0] = 1'b1; out_ready_s[0] = 1'b1;
    step();
    in_valid_s[0] = 1'b0;
    chk("ser_out0", int'(out_s[0]), 0);
    chk("ser_last0", int'(out_last_s[0]), 0);
    step();
    chk("ser_out1", int'(out_s[0]), 1);
    step();
    chk("ser_out3", int'(out_s[0]), 3);
    chk("ser_last3", int'(out_last_s[0]), 1);
    step();
    chk("ser_idle_valid", int'(out_valid_s[0]), 0);
    chk("ser_idle_ready", int'(in_ready_s[0]), 1);

    // Backpressure on a single-bit mask.
    in_s[0] = 4'b0100; in_valid_s[0] = 1'b1; out_ready_s[0] = 1'b0;
    step();
    in_valid_s[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("bp_out", int'(out_s[0]), 2);
      chk("bp_valid", int'(out_valid_s[0]), 1);
      chk("bp_last", int'(out_last_s[0]), 1);
      if (k == 3) out_ready_s[0] = 1'b1;
      step();
    end
    chk("bp_done_valid", int'(out_valid_s[0]), 0);

    // Zero mask.
    in_s[0] = 4'b0000; in_valid_s[0] = 1'b1;
    step();
    in_valid_s[0] = 1'b0;
    chk("zero_valid", int'(out_valid_s[0]), 0);
    chk("zero_ready", int'(in_ready_s[0]), 1);
`ifdef ENCODE42_ZERO_ERR_EN
    chk("zero_err_hi", int'(err_s[0]), 1);
`endif
    step();
`ifdef ENCODE42_ZERO_ERR_EN
    chk("zero_err_lo", int'(err_s[0]), 0);
`endif

    // Reset after two output handshakes of 1111.
    in_s[0] = 4'b1111; in_valid_s[0] = 1'b1;
    step();
    in_valid_s[0] = 1'b0;
    step();
    step();
    chk("mid_out2", int'(out_s[0]), 2);
    reset = 1'b1;
    @(posedge clk);
    model_edge();
    #1 reset = 1'b0;
    @(negedge clk);
    compare_all();
    chk("mid_rst_valid", int'(out_valid_s[0]), 0);
    chk("mid_rst_ready", int'(in_ready_s[0]), 1);
    in_s[0] = 4'b1000; in_valid_s[0] = 1'b1;
    step();
    in_valid_s[0] = 1'b0;
    chk("mid_new_out", int'(out_s[0]), 3);
    chk("mid_new_last", int'(out_last_s[0]), 1);
    step();
    chk("mid_new_done", int'(out_valid_s[0]), 0);

    // Highest-first order on the second instance.
    in_s[1] = 4'b1011; in_valid_s[1] = 1'b1; out_ready_s[1] = 1'b1;
    step();
    in_valid_s[1] = 1'b0;
    chk("msb_out3", int'(out_s[1]), 3);
    step();
    chk("msb_out1", int'(out_s[1]), 1);
    chk("msb_last1", int'(out_last_s[1]), 0);
    step();
    chk("msb_out0", int'(out_s[1]), 0);
    chk("msb_last0", int'(out_last_s[1]), 1);
    step();
    chk("msb_done", int'(out_valid_s[1]), 0);

    // Mixed traffic: masks change freely, valid/ready toggle in patterns.
    for (int c = 0; c < 120; c++) begin
      for (int i = 0; i < 2; i++) begin
        in_s[i]        = 4'((c * 7 + i * 5) & 15);
        in_valid_s[i]  = (c % 4) != 3;
        out_ready_s[i] = ((c + i) % 3) != 0;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
